// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - state encodings, settle bounds and shared types for imem_ctrl
package imem_ctrl_pkg;

    localparam int ADRS_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 3;

    localparam logic [2:0] ST_BOOT    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    typedef logic [ADRS_W-1:0] adrs_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  we;
        adrs_t adrs;
        data_t wdat;
    } ld_acc_t;

    // Terminal HOLD count; out-of-range SETTLE_CYC values are clamped to the legal window.
    function automatic logic [1:0] settle_last(input int sc);
        if (sc <= SETTLE_MIN) return 2'd0;
        if (sc >= SETTLE_MAX) return 2'(SETTLE_MAX - 1);
        return 2'(sc - 1);
    endfunction

endpackage

// File: rtl/imem_ctrl_rom.sv
// rtl/imem_ctrl_rom.sv - 16 x 8 boot image, combinational read
module imem_ctrl_rom
    import imem_ctrl_pkg::*;
(
    input  logic [3:0] adrs,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (adrs)
            4'h0: data = 8'h3C;
            4'h1: data = 8'h01;
            4'h2: data = 8'hE2;
            4'h3: data = 8'h47;
            4'h4: data = 8'h9A;
            4'h5: data = 8'h05;
            4'h6: data = 8'hB6;
            4'h7: data = 8'h28;
            4'h8: data = 8'hD1;
            4'h9: data = 8'h6F;
            4'hA: data = 8'h12;
            4'hB: data = 8'h84;
            4'hC: data = 8'hF0;
            4'hD: data = 8'h5D;
            4'hE: data = 8'hA3;
            4'hF: data = 8'h7E;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction store arbitrated between CPU fetch and loader; IMEM_BOOT_ROM_EN adds ROM boot
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic [3:0] cpu_adrs,
    output logic [7:0] cpu_dat,
    output logic       cpu_hold,
    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [3:0] ld_adrs,
    input  logic [7:0] ld_wdat,
    output logic       ld_gnt,
    output logic       ld_ack,
    output logic [7:0] ld_rdat,
    output logic       boot_done
);

    localparam logic [1:0] HOLD_LAST = settle_last(SETTLE_CYC);

    logic [2:0] state;
    logic [1:0] hold_cnt;
    logic [3:0] boot_cnt;
    data_t      store [DEPTH];
    ld_acc_t    acc;
    logic       ld_fire;
    logic       boot_wr;
    data_t      rom_dat;

    assign acc     = '{we: ld_we, adrs: ld_adrs, wdat: ld_wdat};
    assign ld_fire = (state == ST_LOAD) && ld_req;

`ifdef IMEM_BOOT_ROM_EN
    localparam logic [2:0] RESET_STATE = ST_BOOT;

    imem_ctrl_rom u_rom (
        .adrs (boot_cnt),
        .data (rom_dat)
    );

    assign boot_wr   = (state == ST_BOOT);
    assign boot_done = (state != ST_BOOT);
`else
    localparam logic [2:0] RESET_STATE = ST_RUN;

    assign rom_dat   = '0;
    assign boot_wr   = 1'b0;
    assign boot_done = 1'b1;
`endif

    // Store has no reset so a reset mid-session keeps whatever was loaded.
    always_ff @(posedge clk_cpu) begin
        if (!reset) begin
            if (boot_wr)
                store[boot_cnt] <= rom_dat;
            else if (ld_fire && acc.we)
                store[acc.adrs] <= acc.wdat;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state    <= RESET_STATE;
            hold_cnt <= 2'd0;
            boot_cnt <= 4'd0;
            ld_ack   <= 1'b0;
            ld_rdat  <= 8'h00;
        end else begin
            ld_ack <= ld_fire;
            if (ld_fire)
                ld_rdat <= acc.we ? acc.wdat : store[acc.adrs];

            case (state)
                ST_BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == 4'hF)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (ld_req)
                        state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!ld_req) begin
                        state    <= ST_RELEASE;
                        hold_cnt <= 2'd0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_LOAD;
                        hold_cnt <= 2'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                ST_LOAD: begin
                    if (!ld_req)
                        state <= ST_RELEASE;
                end
                ST_RELEASE: state <= ST_RUN;
                default:    state <= RESET_STATE;
            endcase
        end
    end

    assign cpu_dat  = store[cpu_adrs];
    assign cpu_hold = (state != ST_RUN);
    assign ld_gnt   = (state == ST_LOAD);

endmodule
